// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: shared constants and elaboration-time helpers for the serial sequence detector
package moore_seq_pkg;
  localparam int MAX_PAT_W = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // KMP-style fallback: longest pattern prefix that is a suffix of (matched prefix, b)
  function automatic int next_state(input logic [MAX_PAT_W-1:0] pattern, input int width,
                                    input int state, input logic b, input logic overlap);
    logic [MAX_PAT_W:0] seq;
    logic ok;
    int k, n, r;
    seq = '0;
    k = (state == width && !overlap) ? 0 : state;
    n = k + 1;
    r = 0;
    for (int i = 0; i < k; i++) seq[i] = pattern[width-1-i];
    seq[k] = b;
    for (int j = (n > width) ? width : n; j > 0; j--) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) if (pattern[width-1-i] != seq[n-j+i]) ok = 1'b0;
      if (ok && r == 0) r = j;
    end
    return r;
  endfunction
endpackage

// File: rtl/moore_seq_counter.sv
// moore_seq_counter: saturating match counter with synchronous clear
module moore_seq_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && count_q != '1) ? count_q + CNT_W'(1) : count_q;
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/moore_seq_detector.sv
// moore_seq_detector: Moore serial pattern detector, MSB first; MOORE_SEQ_CNT_EN builds the match counter
module moore_seq_detector
  import moore_seq_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_count
);
  localparam int SW = clog2(PAT_W + 1);
  localparam logic [SW-1:0] S_IDLE  = '0;
  localparam logic [SW-1:0] S_MATCH = SW'(PAT_W);
  logic [SW-1:0] state_q, state_d;
  logic [SW-1:0] tbl [2**SW][2];
  logic          inc;
  if (PAT_W < 2 || PAT_W > MAX_PAT_W) begin : g_bad_w
    $fatal(1, "moore_seq_detector: PAT_W=%0d outside 2..%0d", PAT_W, MAX_PAT_W);
  end
  // Transition table fixed at elaboration; unreachable encodings fall back to idle
  for (genvar s = 0; s < 2**SW; s++) begin : g_s
    for (genvar b = 0; b < 2; b++) begin : g_b
      if (s <= PAT_W) begin : g_v
        assign tbl[s][b] = SW'(next_state(MAX_PAT_W'(PATTERN), PAT_W, s, 1'(b), OVERLAP));
      end else begin : g_u
        assign tbl[s][b] = S_IDLE;
      end
    end
  end
  always_comb state_d = en ? tbl[state_q][din] : state_q;
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end
  assign dout = state_q == S_MATCH;
  assign inc  = en && state_d == S_MATCH;
`ifdef MOORE_SEQ_CNT_EN
  moore_seq_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .clr   (cnt_clr),
    .count (match_count)
  );
`else
  logic unused_cnt;
  assign unused_cnt  = ^{cnt_clr, inc};
  assign match_count = '0;
`endif
endmodule
